// File: rtl/avalon_master_arbiter_pkg.sv
// Shared types and helpers for the Avalon-MM master arbiter.
package avalon_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int NUM_REQ_DFLT     = 2;
  localparam int MAX_PENDING_DFLT = 4;
  localparam int REQ_IDW          = $clog2(NUM_REQ_DFLT);
  localparam int PEND_W           = $clog2(MAX_PENDING_DFLT) + 1;

  // Requester-id width; never zero so a single-bit id still has a vector.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/avalon_master_arbiter_id_fifo.sv
// Ordered record of which requester issued each outstanding read.
// A pop in the same cycle frees the slot for a push even when full.
module arb_id_fifo
  import avalon_arb_pkg::*;
#(
  parameter int DEPTH = MAX_PENDING_DFLT,
  parameter int WIDTH = REQ_IDW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of 2).
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // Pointer/occupancy registers; outstanding ids are dropped on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Id storage, written at the tail on an accepted push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port among NUM_REQ requesters.
// One transaction per grant; read returns are routed back in issue order.
//
// state | meaning
// IDLE  | no owner; pick the next requester at/after rr_ptr
// GRANT | granted requester drives the master port until accepted or it drops
module avalon_master_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int NUM_REQ             = NUM_REQ_DFLT,
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 32,
  parameter int MAX_PENDING         = MAX_PENDING_DFLT
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [NUM_REQ-1:0][MASTER_ADDRESSWIDTH-1:0] req_address,
  input  logic [NUM_REQ-1:0][DATAWIDTH-1:0]           req_writedata,
  input  logic [NUM_REQ-1:0]                          req_write,
  input  logic [NUM_REQ-1:0]                          req_read,
  output logic [NUM_REQ-1:0]                          req_waitrequest,
  output logic [DATAWIDTH-1:0]                        req_readdata,
  output logic [NUM_REQ-1:0]                          req_readdatavalid,
  output logic [MASTER_ADDRESSWIDTH-1:0]              master_address,
  output logic [DATAWIDTH-1:0]                        master_writedata,
  output logic                                        master_write,
  output logic                                        master_read,
  input  logic [DATAWIDTH-1:0]                        master_readdata,
  input  logic                                        master_readdatavalid,
  input  logic                                        master_waitrequest,
  output logic [$clog2(MAX_PENDING):0]                pending_count,
  output logic                                        rd_orphan
);

  localparam int ID_W = id_width(NUM_REQ);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               rd_orphan_q, rd_orphan_d;
  logic [NUM_REQ-1:0] req_any;
  logic               gnt_wr, gnt_rd, rd_slot, strobe;
  logic               id_push, id_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0]    id_head;

  // First requester at or after ptr, searching cyclically.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W:0]   idx;
    logic            found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req_any       = req_write | req_read;
  assign id_pop        = master_readdatavalid & ~fifo_empty;
  assign req_readdata  = master_readdata;
  assign rd_orphan     = rd_orphan_q;

  // Next-state and master-port mux; a write beats a read from the same requester.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_ptr_d         = rr_ptr_q;
    rd_orphan_d      = rd_orphan_q | (master_readdatavalid & fifo_empty);
    master_address   = '0;
    master_writedata = '0;
    master_write     = 1'b0;
    master_read      = 1'b0;
    req_waitrequest  = '1;
    id_push          = 1'b0;
    gnt_wr           = 1'b0;
    gnt_rd           = 1'b0;
    rd_slot          = 1'b0;
    strobe           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_any) begin
          grant_d = rr_pick(req_any, rr_ptr_q);
          state_d = GRANT;
        end
      end
      GRANT: begin
        master_address   = req_address[grant_q];
        master_writedata = req_writedata[grant_q];
        gnt_wr           = req_write[grant_q];
        gnt_rd           = req_read[grant_q] & ~gnt_wr;
        // A return popping this cycle frees the slot a full FIFO would block.
        rd_slot          = ~fifo_full | id_pop;
        master_write     = gnt_wr;
        master_read      = gnt_rd & rd_slot;
        strobe           = gnt_wr | (gnt_rd & rd_slot);
        if (strobe) begin
          req_waitrequest[grant_q] = master_waitrequest;
          if (!master_waitrequest) begin
            rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
            id_push  = gnt_rd;
            state_d  = IDLE;
          end
        end else if (!req_any[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route a read return to the requester at the head of the id FIFO.
  always_comb begin
    req_readdatavalid = '0;
    if (id_pop) req_readdatavalid[id_head] = 1'b1;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      rd_orphan_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      rd_orphan_q <= rd_orphan_d;
    end
  end

  arb_id_fifo #(
    .DEPTH (MAX_PENDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (id_push),
    .push_data (grant_q),
    .pop       (id_pop),
    .head      (id_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending_count)
  );

endmodule

// File: tb/tb_avalon_master_arbiter.sv
// Bench for avalon_master_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_avalon_master_arbiter;

  localparam int NR   = 2;
  localparam int MAW  = 28;
  localparam int DW   = 32;
  localparam int MAXP = 4;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NR-1:0][MAW-1:0]  req_address;
  logic [NR-1:0][DW-1:0]   req_writedata;
  logic [NR-1:0]           req_write;
  logic [NR-1:0]           req_read;
  logic [NR-1:0]           req_waitrequest;
  logic [DW-1:0]           req_readdata;
  logic [NR-1:0]           req_readdatavalid;
  logic [MAW-1:0]          master_address;
  logic [DW-1:0]           master_writedata;
  logic                    master_write;
  logic                    master_read;
  logic [DW-1:0]           master_readdata;
  logic                    master_readdatavalid;
  logic                    master_waitrequest;
  logic [$clog2(MAXP):0]   pending_count;
  logic                    rd_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  avalon_master_arbiter #(
    .NUM_REQ             (NR),
    .MASTER_ADDRESSWIDTH (MAW),
    .DATAWIDTH           (DW),
    .MAX_PENDING         (MAXP)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req_address          (req_address),
    .req_writedata        (req_writedata),
    .req_write            (req_write),
    .req_read             (req_read),
    .req_waitrequest      (req_waitrequest),
    .req_readdata         (req_readdata),
    .req_readdatavalid    (req_readdatavalid),
    .master_address       (master_address),
    .master_writedata     (master_writedata),
    .master_write         (master_write),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_waitrequest   (master_waitrequest),
    .pending_count        (pending_count),
    .rd_orphan            (rd_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // owner: requester currently holding the port (-1 none); prio: who goes first next.
  int   m_owner = -1;
  int   m_prio  = 0;
  int   m_nxt;
  int   m_q[$];
  bit   m_orphan = 1'b0;
  logic e_wr, e_rd, e_pop, e_acc, e_room;
  logic [MAW-1:0] e_addr;
  logic [DW-1:0]  e_data;
  logic [NR-1:0]  e_wait, e_rdv;

  initial begin
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        m_owner  = -1;
        m_prio   = 0;
        m_orphan = 1'b0;
        m_q.delete();
      end else begin
        e_wr = 1'b0; e_rd = 1'b0; e_acc = 1'b0; e_room = 1'b0;
        e_addr = '0; e_data = '0; e_wait = '1; e_rdv = '0;
        e_pop = master_readdatavalid && (m_q.size() > 0);
        if (e_pop) e_rdv[m_q[0]] = 1'b1;
        m_nxt = m_owner;
        if (m_owner < 0) begin
          for (int k = 0; k < NR; k++)
            if (m_nxt < 0 && (req_write[(m_prio + k) % NR] || req_read[(m_prio + k) % NR]))
              m_nxt = (m_prio + k) % NR;
        end else begin
          e_addr = req_address[m_owner];
          e_data = req_writedata[m_owner];
          if (req_write[m_owner]) begin
            e_wr = 1'b1;
            e_wait[m_owner] = master_waitrequest;
            e_acc = !master_waitrequest;
          end else if (req_read[m_owner]) begin
            e_room = (m_q.size() < MAXP) || e_pop;
            e_rd = e_room;
            e_wait[m_owner] = e_room ? master_waitrequest : 1'b1;
            e_acc = e_room && !master_waitrequest;
          end else begin
            m_nxt = -1;
          end
        end
        chk("master_write", master_write, e_wr);
        chk("master_read", master_read, e_rd);
        chk("master_address", master_address, e_addr);
        chk("master_writedata", master_writedata, e_data);
        chk("req_waitrequest", req_waitrequest, e_wait);
        chk("req_readdatavalid", req_readdatavalid, e_rdv);
        chk("req_readdata", req_readdata, master_readdata);
        chk("pending_count", pending_count, m_q.size());
        chk("rd_orphan", rd_orphan, m_orphan);
        if (master_readdatavalid && m_q.size() == 0) m_orphan = 1'b1;
        if (e_pop) void'(m_q.pop_front());
        if (e_acc) begin
          if (e_rd) m_q.push_back(m_owner);
          m_prio = (m_owner + 1) % NR;
          m_nxt  = -1;
        end
        m_owner = m_nxt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    req_address          = '0;
    req_writedata        = '0;
    req_write            = '0;
    req_read             = '0;
    master_readdata      = '0;
    master_readdatavalid = 1'b0;
    master_waitrequest   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    #2;
    reset_n = 1'b1;
  endtask

  logic [NR-1:0] exp_w;
  logic [NR-1:0] acc_seen;
  int            n_acc;
  int            act [NR];

  initial begin
    clear_inputs();
    #2;
    chk("rst_write", master_write, 1'b0);
    chk("rst_read", master_read, 1'b0);
    chk("rst_addr", master_address, 0);
    chk("rst_wait", req_waitrequest, 2'b11);
    chk("rst_rdv", req_readdatavalid, 2'b00);
    chk("rst_pend", pending_count, 0);
    chk("rst_orphan", rd_orphan, 1'b0);
    tick();
    reset_n = 1'b1;

    // single write from requester 0
    req_write[0] = 1'b1; req_address[0] = 28'h8000000; req_writedata[0] = 32'h00FF0000;
    @(negedge clk);
    chk("t1_idle_write", master_write, 1'b0);
    chk("t1_idle_wait", req_waitrequest, 2'b11);
    tick();
    @(negedge clk);
    chk("t1_write", master_write, 1'b1);
    chk("t1_addr", master_address, 28'h8000000);
    chk("t1_data", master_writedata, 32'h00FF0000);
    chk("t1_wait", req_waitrequest, 2'b10);
    tick();
    clear_inputs();

    // both requesters writing continuously: alternating grants, accept every 2nd cycle
    do_reset();
    for (int i = 0; i < NR; i++) begin
      req_write[i] = 1'b1;
      req_address[i] = MAW'(32'h100 * (i + 1));
      req_writedata[i] = 32'hA0 + i;
    end
    n_acc = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) chk("t2_bubble", req_waitrequest, 2'b11);
      else begin
        exp_w = '1;
        exp_w[(k / 2) % 2] = 1'b0;
        chk("t2_grant", req_waitrequest, exp_w);
        chk("t2_addr", master_address, 28'h100 * (((k / 2) % 2) + 1));
      end
      if (!(&req_waitrequest)) n_acc++;
      tick();
    end
    chk("t2_accepts", n_acc, 8);
    clear_inputs();

    // requester 1 write stalled by the bus for 3 cycles
    req_write[1] = 1'b1; req_address[1] = 28'h0800040; req_writedata[1] = 32'hCAFE0001;
    master_waitrequest = 1'b1;
    @(negedge clk);
    chk("t3_idle", master_write, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      chk("t3_hold_write", master_write, 1'b1);
      chk("t3_hold_addr", master_address, 28'h0800040);
      chk("t3_hold_data", master_writedata, 32'hCAFE0001);
      chk("t3_hold_wait", req_waitrequest, 2'b11);
    end
    tick();
    master_waitrequest = 1'b0;
    @(negedge clk);
    chk("t3_acc_addr", master_address, 28'h0800040);
    chk("t3_acc_wait", req_waitrequest, 2'b01);
    tick();
    clear_inputs();

    // two reads, returns routed in issue order
    do_reset();
    req_read = 2'b11; req_address[0] = 28'h0800010; req_address[1] = 28'h0800020;
    @(negedge clk);
    chk("t4_idle", master_read, 1'b0);
    tick();
    @(negedge clk);
    chk("t4_rd0", master_read, 1'b1);
    chk("t4_wait0", req_waitrequest, 2'b10);
    tick();
    req_read[0] = 1'b0;
    @(negedge clk);
    chk("t4_bubble", master_read, 1'b0);
    tick();
    @(negedge clk);
    chk("t4_rd1", master_read, 1'b1);
    chk("t4_wait1", req_waitrequest, 2'b01);
    tick();
    req_read = '0; master_readdatavalid = 1'b1; master_readdata = 32'h0000AAAA;
    @(negedge clk);
    chk("t4_pend2", pending_count, 2);
    chk("t4_rdv0", req_readdatavalid, 2'b01);
    chk("t4_data0", req_readdata, 32'h0000AAAA);
    tick();
    master_readdata = 32'h0000BBBB;
    @(negedge clk);
    chk("t4_rdv1", req_readdatavalid, 2'b10);
    chk("t4_data1", req_readdata, 32'h0000BBBB);
    chk("t4_pend1", pending_count, 1);
    tick();
    master_readdatavalid = 1'b0;
    @(negedge clk);
    chk("t4_pend0", pending_count, 0);
    tick();

    // fill the pending window, then a same-cycle return lets the held read through
    do_reset();
    req_read[0] = 1'b1; req_address[0] = 28'h0800100;
    repeat (9) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("t5_pend4", pending_count, 4);
    chk("t5_held_rd", master_read, 1'b0);
    chk("t5_held_wait", req_waitrequest, 2'b11);
    tick();
    @(negedge clk);
    chk("t5_held_rd2", master_read, 1'b0);
    tick();
    master_readdatavalid = 1'b1; master_readdata = 32'h00001234;
    @(negedge clk);
    chk("t5_swap_rd", master_read, 1'b1);
    chk("t5_swap_wait", req_waitrequest, 2'b10);
    chk("t5_swap_rdv", req_readdatavalid, 2'b01);
    tick();
    req_read = '0; master_readdatavalid = 1'b0;
    @(negedge clk);
    chk("t5_pend_after", pending_count, 4);
    tick();
    master_readdatavalid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      tick();
    end
    master_readdatavalid = 1'b0;
    @(negedge clk);
    chk("t5_drained", pending_count, 0);
    tick();

    // reset while a write is stalled and a read is outstanding
    req_read[1] = 1'b1; req_address[1] = 28'h0800180;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6_rd1", master_read, 1'b1);
    tick();
    req_read = '0; req_write[1] = 1'b1; req_address[1] = 28'h0800200;
    req_writedata[1] = 32'h00005555; master_waitrequest = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t6_pre_write", master_write, 1'b1);
    chk("t6_pre_pend", pending_count, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_write", master_write, 1'b0);
    chk("t6_wait", req_waitrequest, 2'b11);
    chk("t6_pend", pending_count, 0);
    chk("t6_addr", master_address, 0);
    clear_inputs();
    #1;
    reset_n = 1'b1;
    tick();

    // return with nothing pending
    master_readdatavalid = 1'b1; master_readdata = 32'h0000DEAD;
    @(negedge clk);
    chk("orph_novalid", req_readdatavalid, 2'b00);
    chk("orph_pre", rd_orphan, 1'b0);
    tick();
    master_readdatavalid = 1'b0;
    @(negedge clk);
    chk("orph_set", rd_orphan, 1'b1);
    tick();
    @(negedge clk);
    chk("orph_sticky", rd_orphan, 1'b1);
    tick();

    // randomized traffic; requesters hold a request until accepted, occasionally abandon it
    do_reset();
    acc_seen = '0;
    for (int i = 0; i < NR; i++) act[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (acc_seen[i] || act[i] == 0) begin
          case ($urandom_range(0, 3))
            0:       act[i] = 0;
            3:       act[i] = 2;
            default: act[i] = 1;
          endcase
          req_address[i]   = MAW'($urandom);
          req_writedata[i] = $urandom;
        end else if ($urandom_range(0, 31) == 0) begin
          act[i] = 0;
        end
        req_write[i] = (act[i] == 1);
        req_read[i]  = (act[i] == 2);
      end
      master_waitrequest   = ($urandom_range(0, 3) == 0);
      master_readdatavalid = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      master_readdata      = $urandom;
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        acc_seen[i] = (req_write[i] | req_read[i]) & ~req_waitrequest[i];
      tick();
    end
    clear_inputs();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
